// File: rtl/core_pkg.sv
// Shared types, defaults and helpers for the branch predictor slice of the MIPS core.
package core_pkg;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Saturating step of a counter of width w (w <= 32); never wraps.
    function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr, input logic up,
                                                 input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (up) return (ctr >= top) ? ctr : ctr + 32'd1;
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

    localparam int unsigned PC_W_DEF    = 7;
    localparam int unsigned ENTRIES_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 2;
    localparam int unsigned STAT_W_DEF  = 16;
    localparam int unsigned IDX_W_DEF   = clog2(ENTRIES_DEF);
    localparam int unsigned TAG_W_DEF   = PC_W_DEF - IDX_W_DEF - 2;

    // One BTB entry at the default core configuration.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [PC_W_DEF-1:0]  target;
        logic [CNT_W_DEF-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup, ID resolve and statistics bundle between the core and the predictor.
interface branch_predictor_if
    import core_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned STAT_W = STAT_W_DEF
);
    logic              if_stall;
    logic              if_flush;
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              id_resolve;
    logic              id_taken;
    logic [PC_W-1:0]   id_target;
    logic              mispredict;
    logic [PC_W-1:0]   correct_pc;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, if_stall, if_flush, id_resolve, id_taken, id_target,
        input  pred_taken, pred_target, mispredict, correct_pc, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, if_stall, if_flush, id_resolve, id_taken, id_target,
        output pred_taken, pred_target, mispredict, correct_pc, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up/down saturating counter with synchronous load; used for BTB counters and statistics.
module sat_counter
    import core_pkg::*;
#(
    parameter int unsigned    W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    // Load takes priority over a counting step; saturates at zero and all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= W'(sat_ctr_next(32'(q), up, W));
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, IF/ID prediction shadow and
// mispredict detection at ID.
module branch_predictor
    import core_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned STAT_W  = STAT_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bus
);

    localparam int unsigned IDX_W   = clog2(ENTRIES);
    localparam int          TAG_RAW = int'(PC_W) - int'(IDX_W) - 2;
    localparam bit          HAS_TAG = (TAG_RAW > 0);
    localparam int unsigned TAG_W   = HAS_TAG ? unsigned'(TAG_RAW) : 1;
    localparam logic [CNT_W-1:0] CTR_WNT = CNT_W'((64'd1 << (CNT_W - 1)) - 64'd1);
    localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(64'd1 << (CNT_W - 1));

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    // Without tag bits every valid entry hits.
    function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
        if (HAS_TAG) return TAG_W'(pc >> (IDX_W + 2));
        return '0;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [CNT_W-1:0]   ctr_q    [ENTRIES];

    logic               sh_valid;
    logic [PC_W-1:0]    sh_pc;
    logic               sh_pred_taken;
    logic [PC_W-1:0]    sh_pred_target;

    logic [IDX_W-1:0]   lk_idx;
    logic               lk_hit;
    logic               pred_taken_c;
    logic [PC_W-1:0]    pred_target_c;

    logic               res_eff;
    logic               mispredict_c;
    logic [PC_W-1:0]    correct_pc_c;
    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_hit;
    logic               alloc;

    logic [STAT_W-1:0]  branch_cnt_q;
    logic [STAT_W-1:0]  mispred_cnt_q;

    // Same-cycle BTB lookup for the PC being fetched.
    always_comb begin
        lk_idx        = idx_of(bus.if_pc);
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == tag_of(bus.if_pc));
        pred_taken_c  = lk_hit && ctr_q[lk_idx][CNT_W-1];
        pred_target_c = pred_taken_c ? target_q[lk_idx] : bus.if_pc + PC_W'(4);
    end

    // Prediction travels with the instruction from IF into ID; flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid       <= 1'b0;
            sh_pc          <= '0;
            sh_pred_taken  <= 1'b0;
            sh_pred_target <= '0;
        end else if (bus.if_flush) begin
            sh_valid       <= 1'b0;
        end else if (!bus.if_stall) begin
            sh_valid       <= 1'b1;
            sh_pc          <= bus.if_pc;
            sh_pred_taken  <= pred_taken_c;
            sh_pred_target <= pred_target_c;
        end
    end

    // Resolve check in ID; a stalled branch only counts on the cycle it leaves ID.
    always_comb begin
        res_eff      = bus.id_resolve && sh_valid && !bus.if_stall;
        mispredict_c = 1'b0;
        if (res_eff) begin
            mispredict_c = (bus.id_taken != sh_pred_taken) ||
                           (bus.id_taken && (bus.id_target != sh_pred_target));
        end
        correct_pc_c = (rst_n && bus.id_taken) ? bus.id_target : sh_pc + PC_W'(4);
        wr_idx       = idx_of(sh_pc);
        wr_tag       = tag_of(sh_pc);
        wr_hit       = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        alloc        = res_eff && !wr_hit && bus.id_taken;
    end

    // Any taken resolve (hit refresh or allocate) writes valid, tag and target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (res_eff && bus.id_taken) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= bus.id_target;
        end
    end

    for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
        sat_counter #(.W(CNT_W), .RST_VAL(CTR_WNT)) u_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (res_eff && wr_hit && (wr_idx == IDX_W'(i))),
            .up       (bus.id_taken),
            .load     (alloc && (wr_idx == IDX_W'(i))),
            .load_val (CTR_WT),
            .q        (ctr_q[i])
        );
    end

    sat_counter #(.W(STAT_W)) u_branch_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (res_eff),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .q        (branch_cnt_q)
    );

    sat_counter #(.W(STAT_W)) u_mispred_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (mispredict_c),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .q        (mispred_cnt_q)
    );

    assign bus.pred_taken  = pred_taken_c;
    assign bus.pred_target = pred_target_c;
    assign bus.mispredict  = mispredict_c;
    assign bus.correct_pc  = correct_pc_c;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural BTB model.
module tb_branch_predictor;
    import core_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] if_pc = '0;
    logic       if_stall = 1'b0;
    logic       if_flush = 1'b0;
    logic       id_resolve = 1'b0;
    logic       id_taken = 1'b0;
    logic [6:0] id_target = '0;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor_if #(.PC_W(7), .STAT_W(16)) bus_a ();
    branch_predictor_if #(.PC_W(7), .STAT_W(2))  bus_b ();

    assign bus_a.if_pc      = if_pc;
    assign bus_a.if_stall   = if_stall;
    assign bus_a.if_flush   = if_flush;
    assign bus_a.id_resolve = id_resolve;
    assign bus_a.id_taken   = id_taken;
    assign bus_a.id_target  = id_target;
    assign bus_b.if_pc      = if_pc;
    assign bus_b.if_stall   = if_stall;
    assign bus_b.if_flush   = if_flush;
    assign bus_b.id_resolve = id_resolve;
    assign bus_b.id_taken   = id_taken;
    assign bus_b.id_target  = id_target;

    branch_predictor #(.PC_W(7), .ENTRIES(8), .CNT_W(2), .STAT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    branch_predictor #(.PC_W(7), .ENTRIES(8), .CNT_W(2), .STAT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    btb_entry_t m_tab [8];
    bit         m_sv;
    logic [6:0] m_spc;
    bit         m_spt;
    logic [6:0] m_sptgt;
    int         m_branches;
    int         m_mispreds;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int mx);
        return 32'((v > mx) ? mx : v);
    endfunction

    // Predict taken only for a tag-matching valid entry whose counter is in the upper half.
    function automatic void lookup(input logic [6:0] pc, output bit t, output logic [6:0] tgt);
        btb_entry_t e;
        e   = m_tab[pc[4:2]];
        t   = e.valid && (e.tag == pc[6:5]) && (e.ctr >= 2'd2);
        tgt = t ? e.target : 7'(pc + 7'd4);
    endfunction

    function automatic bit exp_misp();
        bit eff;
        eff = id_resolve && m_sv && !if_stall;
        return eff && ((id_taken != m_spt) || (id_taken && (id_target != m_sptgt)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tab[i] = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'd1};
        m_sv = 0; m_spc = '0; m_spt = 0; m_sptgt = '0;
        m_branches = 0; m_mispreds = 0;
    endtask

    task automatic model_step();
        bit pt, eff, hit;
        logic [6:0] ptgt;
        logic [2:0] wi;
        lookup(if_pc, pt, ptgt);
        eff = id_resolve && m_sv && !if_stall;
        if (eff) begin
            m_branches++;
            if (exp_misp()) m_mispreds++;
            wi  = m_spc[4:2];
            hit = m_tab[wi].valid && (m_tab[wi].tag == m_spc[6:5]);
            if (hit) begin
                if (id_taken) begin
                    if (m_tab[wi].ctr != 2'd3) m_tab[wi].ctr = m_tab[wi].ctr + 2'd1;
                    m_tab[wi].target = id_target;
                end else if (m_tab[wi].ctr != 2'd0) begin
                    m_tab[wi].ctr = m_tab[wi].ctr - 2'd1;
                end
            end else if (id_taken) begin
                m_tab[wi] = '{valid: 1'b1, tag: m_spc[6:5], target: id_target, ctr: 2'd2};
            end
        end
        if (if_flush) m_sv = 0;
        else if (!if_stall) begin
            m_sv = 1; m_spc = if_pc; m_spt = pt; m_sptgt = ptgt;
        end
    endtask

    // Model follows the DUT edges; reset is asynchronous.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        bit         pt;
        logic [6:0] ptgt;
        logic [6:0] cpc;
        forever begin
            @(negedge clk);
            lookup(if_pc, pt, ptgt);
            cpc = (rst_n && id_taken) ? id_target : 7'(m_spc + 7'd4);
            chk("pred_taken",    32'(bus_a.pred_taken),  32'(pt));
            chk("pred_target",   32'(bus_a.pred_target), 32'(ptgt));
            chk("mispredict",    32'(bus_a.mispredict),  32'(exp_misp()));
            chk("correct_pc",    32'(bus_a.correct_pc),  32'(cpc));
            chk("branch_cnt",    32'(bus_a.branch_cnt),  sat(m_branches, 65535));
            chk("mispred_cnt",   32'(bus_a.mispred_cnt), sat(m_mispreds, 65535));
            chk("b_pred_taken",  32'(bus_b.pred_taken),  32'(pt));
            chk("b_mispredict",  32'(bus_b.mispredict),  32'(exp_misp()));
            chk("b_branch_cnt",  32'(bus_b.branch_cnt),  sat(m_branches, 3));
            chk("b_mispred_cnt", 32'(bus_b.mispred_cnt), sat(m_mispreds, 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [6:0] pc, input bit st, input bit fl,
                         input bit rs, input bit tk, input logic [6:0] tg);
        if_pc = pc; if_stall = st; if_flush = fl;
        id_resolve = rs; id_taken = tk; id_target = tg;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Outputs while held in reset, with a taken resolve presented.
        drive(7'h00, 0, 0, 1, 1, 7'h33);
        at_sample();
        chk("rst_pred_taken",  32'(bus_a.pred_taken),  32'd0);
        chk("rst_pred_target", 32'(bus_a.pred_target), 32'h04);
        chk("rst_mispredict",  32'(bus_a.mispredict),  32'd0);
        chk("rst_correct_pc",  32'(bus_a.correct_pc),  32'h04);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Cold miss then taken resolve.
        drive(7'h10, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t1_pred_taken",  32'(bus_a.pred_taken),  32'd0);
        chk("t1_pred_target", 32'(bus_a.pred_target), 32'h14);
        chk("t1_branch_cnt",  32'(bus_a.branch_cnt),  32'd0);
        next_cycle();
        drive(7'h00, 0, 0, 1, 1, 7'h40);
        at_sample();
        chk("t1_mispredict", 32'(bus_a.mispredict), 32'd1);
        chk("t1_correct_pc", 32'(bus_a.correct_pc), 32'h40);
        next_cycle();

        // Allocated entry now predicts taken.
        drive(7'h10, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t2_pred_taken",  32'(bus_a.pred_taken),  32'd1);
        chk("t2_pred_target", 32'(bus_a.pred_target), 32'h40);
        chk("t2_branch_cnt",  32'(bus_a.branch_cnt),  32'd1);
        chk("t2_mispred_cnt", 32'(bus_a.mispred_cnt), 32'd1);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(7'h10, 0, 0, 1, 1, 7'h40);
            at_sample();
            chk("t2_taken_ok", 32'(bus_a.mispredict), 32'd0);
            next_cycle();
        end

        // Two not-taken resolves pull the saturated counter down to weakly not-taken.
        drive(7'h10, 0, 0, 1, 0, 7'h00);
        at_sample();
        chk("t3_mispredict", 32'(bus_a.mispredict), 32'd1);
        chk("t3_correct_pc", 32'(bus_a.correct_pc), 32'h14);
        next_cycle();
        drive(7'h10, 0, 0, 1, 0, 7'h00);
        at_sample();
        chk("t3_mispredict2", 32'(bus_a.mispredict), 32'd1);
        next_cycle();
        drive(7'h10, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t3_pred_taken",    32'(bus_a.pred_taken),  32'd0);
        chk("t3_branch_cnt",    32'(bus_a.branch_cnt),  32'd8);
        chk("t3_mispred_cnt",   32'(bus_a.mispred_cnt), 32'd3);
        chk("t3_b_branch_sat",  32'(bus_b.branch_cnt),  32'd3);
        next_cycle();

        // Aliasing branch at 0x30 evicts the 0x10 entry.
        drive(7'h30, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t4_alias_miss", 32'(bus_a.pred_taken), 32'd0);
        next_cycle();
        drive(7'h10, 0, 0, 1, 1, 7'h50);
        at_sample();
        chk("t4_mispredict", 32'(bus_a.mispredict), 32'd1);
        chk("t4_correct_pc", 32'(bus_a.correct_pc), 32'h50);
        next_cycle();
        drive(7'h10, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t4_evicted", 32'(bus_a.pred_taken), 32'd0);
        next_cycle();
        drive(7'h30, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t4_new_taken",  32'(bus_a.pred_taken),  32'd1);
        chk("t4_new_target", 32'(bus_a.pred_target), 32'h50);
        next_cycle();

        // Stalled branch resolves exactly once on release.
        for (int i = 0; i < 2; i++) begin
            drive(7'h00, 1, 0, 1, 1, 7'h60);
            at_sample();
            chk("t5_stalled_quiet", 32'(bus_a.mispredict), 32'd0);
            next_cycle();
        end
        drive(7'h00, 0, 0, 1, 1, 7'h60);
        at_sample();
        chk("t5_release_misp", 32'(bus_a.mispredict), 32'd1);
        chk("t5_release_cpc",  32'(bus_a.correct_pc), 32'h60);
        next_cycle();
        drive(7'h00, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t5_branch_cnt",   32'(bus_a.branch_cnt),  32'd10);
        chk("t5_mispred_cnt",  32'(bus_a.mispred_cnt), 32'd5);
        chk("t6_b_mispred_sat", 32'(bus_b.mispred_cnt), 32'd3);
        next_cycle();

        // Flush together with stall leaves a bubble in ID.
        drive(7'h14, 1, 1, 0, 0, 7'h00);
        next_cycle();
        drive(7'h14, 0, 0, 1, 1, 7'h20);
        at_sample();
        chk("t5_bubble_quiet", 32'(bus_a.mispredict), 32'd0);
        next_cycle();
        drive(7'h30, 0, 0, 0, 0, 7'h00);
        at_sample();
        chk("t5_bubble_cnt", 32'(bus_a.branch_cnt), 32'd10);

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_branch", 32'(bus_a.branch_cnt),  32'd0);
        chk("t6_async_misp",   32'(bus_b.mispred_cnt), 32'd0);
        chk("t6_async_table",  32'(bus_a.pred_taken),  32'd0);
        next_cycle();
        rst_n = 1'b1;
        at_sample();
        chk("t6_after_rst", 32'(bus_a.pred_taken), 32'd0);
        next_cycle();

        // Randomized traffic over an aliasing-heavy address pool.
        for (int c = 0; c < 3000; c++) begin
            drive(7'($urandom_range(0, 31) << 2),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 60),
                  7'($urandom_range(0, 31) << 2));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS core: a direct-mapped BTB with per-entry saturating counters.
- It replaces the fixed predict-not-taken behaviour, where every taken branch or jump costs one flushed IF slot.
- IF looks up if_pc combinationally. The prediction rides a one-entry internal IF/ID shadow register. ID resolves the branch, and the block flags a mispredict with the corrected PC.
- Saturating performance counters track branches and mispredicts.

Parameters:
- PC_W, 7: PC/address width; matches the core PC.
- ENTRIES, 8: BTB depth; power of 2, at least 2. IDX_W = log2(ENTRIES).
- CNT_W, 2: saturating counter width, at least 1.
- STAT_W, 16: performance counter width.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_W  PC being fetched this cycle
- if_stall  in  1  IF/ID hold (load-use or branch-operand stall); high freezes the shadow register
- if_flush  in  1  IF/ID flush from the core; next shadow content becomes a bubble
- pred_taken  out  1  predicted redirect for if_pc
- pred_target  out  PC_W  predicted next PC; equals if_pc+4 when pred_taken=0
- id_resolve  in  1  instruction in ID is a branch or jump, resolved this cycle
- id_taken  in  1  actual direction (jumps always 1)
- id_target  in  PC_W  actual taken target
- mispredict  out  1  ID outcome differs from the prediction carried with it
- correct_pc  out  PC_W  PC to load when mispredict=1
- branch_cnt  out  STAT_W  resolved branches
- mispred_cnt  out  STAT_W  mispredicts

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2]
  - tag = pc[PC_W-1:IDX_W+2]
  - If PC_W-IDX_W-2 is at most 0, there is no tag and an entry hits whenever it is valid.
- Entry contents: valid, tag, target[PC_W], ctr[CNT_W].
- Lookup (combinational, same cycle):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr MSB.
  - pred_target = pred_taken ? target : if_pc+4, modulo 2^PC_W.
- Shadow register (valid, pc, pred_taken, pred_target) at each clk edge:
  - if_flush=1: valid <= 0. Flush wins over stall.
  - else if if_stall=0: load {1, if_pc, pred_taken, pred_target}.
  - else: hold.
- Resolve is effective only when id_resolve=1, shadow valid=1 and if_stall=0. A stalled branch resolves once, on the cycle it leaves ID.
- mispredict (combinational, effective resolve only) is 1 when either holds:
  - id_taken differs from shadow pred_taken;
  - both taken and id_target differs from shadow pred_target.
- correct_pc = id_taken ? id_target : shadow pc+4.
- mispredict=0 whenever resolve is not effective. The core uses mispredict in place of its raw Branch|Jump redirect.
- Table update at the clk edge after an effective resolve, at idx(shadow pc):
  - Hit: ctr saturating +1 if taken, -1 if not; no wrap at all-ones or zero. If taken, target <= id_target.
  - Miss and taken: allocate valid=1, tag, target=id_target, ctr=2^(CNT_W-1) (weakly taken), overwriting any occupant.
  - Miss and not taken: no change.
- Same-index read/write in one cycle: the lookup sees the pre-update entry; the update is visible from the next cycle.
- Statistics:
  - branch_cnt +1 per effective resolve; mispred_cnt +1 when mispredict=1.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, rst_n=0):
  - All valid <= 0, all ctr <= 2^(CNT_W-1)-1 (weakly not-taken), target/tag <= 0.
  - Shadow valid <= 0, pc/pred <= 0.
  - Statistics <= 0.
  - Outputs during reset: pred_taken=0, pred_target=if_pc+4, mispredict=0, correct_pc=4.
  - Reset mid-operation discards any pending update.
  - On release, the first edge behaves as a normal load.

Decomposition:
- Shared package core_pkg holds:
  - PC_W default
  - function clog2
  - typedef btb_entry_t {valid, tag, target, ctr}
  - function sat_ctr_next(ctr, up)
- One sub-module, sat_counter (CNT_W, up/down/enable), is reused for table counters and statistics (STAT_W, up-only).
- Table storage is a flop array, not an SRAM, because lookup is asynchronous.

Test Plan:
1. Reset then fetch if_pc=0x10 -> pred_taken=0, pred_target=0x14.
   Resolve id_taken=1, id_target=0x40 -> mispredict=1, correct_pc=0x40, branch_cnt=1, mispred_cnt=1.
2. Refetch 0x10 next cycle -> pred_taken=1, pred_target=0x40.
   Resolve taken 0x40 -> mispredict=0; ctr goes 2->3. Four more taken resolves -> ctr stays 3.
3. Entry at 0x10 with ctr=3, resolve not-taken twice -> first resolve mispredict=1, correct_pc=0x14, ctr=2; second ctr=1 and pred_taken=0 on the following fetch.
4. With ENTRIES=8, PC_W=7, allocate 0x10, then taken branch at 0x30 (same idx 4, different tag) -> 0x30 overwrites; fetch 0x10 -> miss, pred_taken=0.
5. Branch in ID with if_stall=1 for 2 cycles and id_resolve held -> no update and mispredict=0 while stalled; exactly one update and branch_cnt+1 on release. Simultaneous if_flush and if_stall -> shadow valid=0.
6. STAT_W=2: 5 mispredicting resolves -> mispred_cnt=3 and holds. Assert rst_n mid-stream -> all counters 0 and the table invalid immediately, without waiting for clk.
